// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial transmit engine.
// Holds the FSM state encoding so the refresh controller and the bench can
// decode the engine state in waves, plus a small sizing helper.
package max7219_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD
   } state_t;

   // Largest of three timing values, used to size the shared down-counter.
   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/max7219.sv
// MAX7219 serial transmit engine.
// Accepts a parallel word on a one-cycle start strobe and shifts it MSB first
// onto a 3-wire interface (cs low-active, sclk idle low, dout). Setup, hold
// and sclk period are programmable in clk cycles.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   start in   one-cycle request, sampled only when idle
//   data  in   word to send, captured on the accepted start cycle
//   cs    out  chip select, active low
//   sclk  out  serial clock
//   dout  out  serial data, MSB first
//   busy  out  high from acceptance until cs returns high
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs high, waiting for start
// SETUP | cs low, first bit on dout, waiting before first sclk rise
// HIGH  | sclk high, slave samples dout
// LOW   | sclk low, dout already advanced to the next bit
// HOLD  | last bit done, cs still low before release
module max7219
   import max7219_pkg::*;
#(
   parameter int CS_FALL_TO_FIRST_SCLK_RISE = 10,
   parameter int LAST_SCLK_FALL_TO_CS_RISE  = 10,
   parameter int CLK_PER_SCLK               = 10,
   parameter int DATABITS                   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATABITS-1:0] data,
   output logic                cs,
   output logic                sclk,
   output logic                dout,
   output logic                busy
);

   localparam int H_CYC = CLK_PER_SCLK / 2;
   localparam int L_CYC = CLK_PER_SCLK - H_CYC;
   localparam int CW    = $clog2(max_of3(CS_FALL_TO_FIRST_SCLK_RISE,
                                         LAST_SCLK_FALL_TO_CS_RISE,
                                         CLK_PER_SCLK));
   localparam int BW    = $clog2(DATABITS + 1);

   // The shared counter is loaded with (duration - 1) and the state moves on
   // when it reaches zero, so each state lasts exactly its duration.
   localparam logic [CW-1:0] LD_SETUP = CW'(CS_FALL_TO_FIRST_SCLK_RISE - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(LAST_SCLK_FALL_TO_CS_RISE - 1);
   localparam logic [CW-1:0] LD_HIGH  = CW'(H_CYC - 1);
   localparam logic [CW-1:0] LD_LOW   = CW'(L_CYC - 1);

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [BW-1:0]       bits_left;
   logic [DATABITS-1:0] sh;
   logic [DATABITS-1:0] sh_nxt;

   assign sh_nxt = sh << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bits_left <= '0;
         sh        <= '0;
         cs        <= 1'b1;
         sclk      <= 1'b0;
         dout      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SETUP;
                  cnt       <= LD_SETUP;
                  bits_left <= BW'(DATABITS);
                  sh        <= data;
                  cs        <= 1'b0;
                  busy      <= 1'b1;
                  sclk      <= 1'b0;
                  dout      <= data[DATABITS-1];
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state <= HIGH;
                  cnt   <= LD_HIGH;
                  sclk  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HIGH: begin
               if (cnt == '0) begin
                  bits_left <= bits_left - BW'(1);
                  sclk      <= 1'b0;
                  if (bits_left == BW'(1)) begin
                     // dout keeps the last bit through the hold time
                     state <= HOLD;
                     cnt   <= LD_HOLD;
                  end else begin
                     state <= LOW;
                     cnt   <= LD_LOW;
                     sh    <= sh_nxt;
                     dout  <= sh_nxt[DATABITS-1];
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            LOW: begin
               if (cnt == '0) begin
                  state <= HIGH;
                  cnt   <= LD_HIGH;
                  sclk  <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  cs    <= 1'b1;
                  busy  <= 1'b0;
                  dout  <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219.sv
// Bench for max7219: two instances (1000/1000/100/16 and 1/1/3/8), a
// closed-form timing model checked every cycle, and a pin-level monitor
// whose frame measurements are pinned against hand-computed values.
module tb_max7219;

   localparam int S_P[2]  = '{1000, 1};
   localparam int HD_P[2] = '{1000, 1};
   localparam int P_P[2]  = '{100, 3};
   localparam int N_P[2]  = '{16, 8};

   logic        clk = 1'b0;
   logic        rst_s[2];
   logic        start_s[2];
   logic [15:0] data_s[2];
   logic        cs_s[2], sclk_s[2], dout_s[2], busy_s[2];

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   max7219 #(
      .CS_FALL_TO_FIRST_SCLK_RISE(1000),
      .LAST_SCLK_FALL_TO_CS_RISE(1000),
      .CLK_PER_SCLK(100),
      .DATABITS(16)
   ) dut_a (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .data(data_s[0]),
      .cs(cs_s[0]), .sclk(sclk_s[0]), .dout(dout_s[0]), .busy(busy_s[0])
   );

   max7219 #(
      .CS_FALL_TO_FIRST_SCLK_RISE(1),
      .LAST_SCLK_FALL_TO_CS_RISE(1),
      .CLK_PER_SCLK(3),
      .DATABITS(8)
   ) dut_o (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .data(data_s[1][7:0]),
      .cs(cs_s[1]), .sclk(sclk_s[1]), .dout(dout_s[1]), .busy(busy_s[1])
   );

   // ---------------- model: frame position k since acceptance ----------------
   bit          act[2];
   int          kpos[2];
   logic [15:0] dat[2];

   function automatic int busy_len(input int i);
      int h, l;
      h = P_P[i] / 2;
      l = P_P[i] - h;
      return S_P[i] + N_P[i] * h + (N_P[i] - 1) * l + HD_P[i];
   endfunction

   // Returns {cs, sclk, dout, busy} for cycle k (1 = first cycle after accept).
   function automatic logic [3:0] expect_out(input int i, input bit a,
                                             input int k, input logic [15:0] d);
      int h, l, n, j, m, bi, ph, idx;
      h = P_P[i] / 2;
      l = P_P[i] - h;
      n = N_P[i];
      if (!a) return 4'b1000;
      j = k - 1;
      if (j < S_P[i]) begin
         idx = n - 1;
         return {1'b0, 1'b0, d[idx], 1'b1};
      end
      m = j - S_P[i];
      if (m < n * P_P[i] - l) begin
         bi = m / P_P[i];
         ph = m % P_P[i];
         if (ph < h) begin
            idx = n - 1 - bi;
            return {1'b0, 1'b1, d[idx], 1'b1};
         end
         idx = n - 2 - bi;
         return {1'b0, 1'b0, d[idx], 1'b1};
      end
      return {1'b0, 1'b0, d[0], 1'b1};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_s[i]) begin
            act[i] = 1'b0;
         end else if (act[i]) begin
            if (kpos[i] == busy_len(i)) act[i] = 1'b0;
            else kpos[i] = kpos[i] + 1;
         end else if (start_s[i]) begin
            act[i]  = 1'b1;
            kpos[i] = 1;
            dat[i]  = data_s[i];
         end
      end
      check_en = 1'b1;
   end

   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] e, o;
            e = expect_out(i, act[i], kpos[i], dat[i]);
            o = {cs_s[i], sclk_s[i], dout_s[i], busy_s[i]};
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL cycle_model dut%0d t=%0t k=%0d {cs,sclk,dout,busy} got %b want %b",
                        i, $time, kpos[i], o, e);
            end
         end
      end
   end

   // ---------------- pin monitor: measures each frame ----------------
   logic        prev_cs[2], prev_sclk[2];
   int          len_m[2], rises_m[2], first_m[2], lastf_m[2], hold_m[2];
   int          done_m[2], falls_m[2];
   logic [15:0] word_m[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0;
         len_m[i] = 0; rises_m[i] = 0; first_m[i] = -1; lastf_m[i] = 0;
         hold_m[i] = 0; done_m[i] = 0; falls_m[i] = 0; word_m[i] = '0;
         act[i] = 1'b0; kpos[i] = 0; dat[i] = '0;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_s[i]) begin
               falls_m[i]++;
               len_m[i] = 0; rises_m[i] = 0; first_m[i] = -1;
               lastf_m[i] = 0; word_m[i] = '0;
            end
            if (!cs_s[i]) begin
               len_m[i]++;
               if (!prev_sclk[i] && sclk_s[i]) begin
                  rises_m[i]++;
                  word_m[i] = {word_m[i][14:0], dout_s[i]};
                  if (rises_m[i] == 1) first_m[i] = len_m[i] - 1;
               end
               if (prev_sclk[i] && !sclk_s[i]) lastf_m[i] = len_m[i];
            end
            if (!prev_cs[i] && cs_s[i]) begin
               hold_m[i] = len_m[i] + 1 - lastf_m[i];
               done_m[i]++;
            end
            prev_cs[i]   = cs_s[i];
            prev_sclk[i] = sclk_s[i];
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic chk(input string nm, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", nm, actual, actual,
                  expected, expected);
      end
   endtask

   // Raises start now; drops it at the next negedge and scrambles data.
   task automatic pulse(input int i, input logic [15:0] d);
      start_s[i] = 1'b1;
      data_s[i]  = d;
      @(negedge clk);
      start_s[i] = 1'b0;
      data_s[i]  = ~d;
   endtask

   task automatic wait_frame(input int i, input string nm);
      int d0, n;
      d0 = done_m[i];
      n  = 0;
      while (done_m[i] == d0 && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_m[i] == d0) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic check_frame16(input string nm, input int word);
      chk({nm, "_word"}, int'(word_m[0]), word);
      chk({nm, "_rises"}, rises_m[0], 16);
      chk({nm, "_cs_low"}, len_m[0], 3550);
      chk({nm, "_first_rise"}, first_m[0], 1000);
      chk({nm, "_hold"}, hold_m[0], 1000);
   endtask

   initial begin
      int f0, n;
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b1; start_s[i] = 1'b1; data_s[i] = 16'hFFFF;
      end
      repeat (10) @(negedge clk);
      #1;
      chk("reset_cs", cs_s[0], 1);
      chk("reset_sclk", sclk_s[0], 0);
      chk("reset_dout", dout_s[0], 0);
      chk("reset_busy", busy_s[0], 0);
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b0; start_s[i] = 1'b0; data_s[i] = '0;
      end
      repeat (5) @(negedge clk);
      #1;
      chk("reset_no_frame", falls_m[0] + falls_m[1], 0);

      // Frame 0x1234
      @(negedge clk);
      pulse(0, 16'h1234);
      #1;
      chk("latency_cs", cs_s[0], 0);
      chk("latency_busy", busy_s[0], 1);
      wait_frame(0, "f1234");
      check_frame16("f1234", 'h1234);

      // Back-to-back after 1 us
      repeat (100) @(negedge clk);
      pulse(0, 16'h5555);
      wait_frame(0, "f5555");
      check_frame16("f5555", 'h5555);

      // Start on the first cs-high cycle, then an ignored start mid-frame
      pulse(0, 16'h1234);
      repeat (1500) @(negedge clk);
      pulse(0, 16'hFFFF);
      wait_frame(0, "fign");
      check_frame16("fign", 'h1234);
      f0 = falls_m[0];
      repeat (200) @(negedge clk);
      #1;
      chk("no_second_frame", falls_m[0], f0);

      // Abort after 5 sclk rises
      @(negedge clk);
      pulse(0, 16'h1234);
      @(negedge clk); #1;
      n = 0;
      while (rises_m[0] < 5 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("abort_reach_5", rises_m[0], 5);
      rst_s[0] = 1'b1;
      @(negedge clk); #1;
      chk("abort_cs", cs_s[0], 1);
      chk("abort_sclk", sclk_s[0], 0);
      chk("abort_busy", busy_s[0], 0);
      rst_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      pulse(0, 16'h00FF);
      wait_frame(0, "fafter");
      check_frame16("fafter", 'h00FF);

      // Odd period instance
      @(negedge clk);
      pulse(1, 16'h00A5);
      wait_frame(1, "fodd");
      chk("odd_word", int'(word_m[1][7:0]), 'hA5);
      chk("odd_rises", rises_m[1], 8);
      chk("odd_busy_len", len_m[1], 24);
      chk("odd_first_rise", first_m[1], 1);
      chk("odd_hold", hold_m[1], 1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
